// File: rtl/compress_line_sequencer.sv
// Sequencer for the line compressor's bit-packing datapath: turns per-symbol lengths
// into write/push/pad commands, aborts lines that overflow the budget, reports line status.
module compress_line_sequencer #(
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned WORD_SIZE  = 64,
  parameter int unsigned N_SYMBOLS  = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_len_valid,
  input  logic [6:0] i_len,
  output logic       o_len_ready,
  output logic       o_wr_en,
  output logic [5:0] o_wr_offset,
  output logic [6:0] o_wr_len,
  output logic       o_word_push,
  output logic       o_pad_en,
  output logic       o_abort,
  output logic       o_line_valid,
  output logic       o_line_compressed,
  output logic [7:0] o_line_bits,
  input  logic       i_line_ready,
  output logic       o_busy
);

  localparam int unsigned OFF_W      = 6;
  localparam int unsigned LEN_W      = 7;
  localparam int unsigned BITS_W     = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PUSH_W     = 2;
  localparam int unsigned LINE_WORDS = CACHE_LINE / WORD_SIZE;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_PAD    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  sym_cnt, sym_cnt_d;
  logic [BITS_W-1:0] total, total_d;
  logic [OFF_W-1:0]  fill, fill_d;
  logic [PUSH_W-1:0] pushed, pushed_d;
  logic              compressed, compressed_d;

  logic [BITS_W:0]   nt;
  logic [LEN_W-1:0]  nf;
  logic [PUSH_W-1:0] pushed_inc;
  logic              last_sym;
  logic              overflow;

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      sym_cnt    <= '0;
      total      <= '0;
      fill       <= '0;
      pushed     <= '0;
      compressed <= 1'b0;
    end else begin
      state      <= state_d;
      sym_cnt    <= sym_cnt_d;
      total      <= total_d;
      fill       <= fill_d;
      pushed     <= pushed_d;
      compressed <= compressed_d;
    end
  end

  // Next-state and command decode; ACCEPT commands follow the length handshake directly
  always_comb begin
    state_d           = state;
    sym_cnt_d         = sym_cnt;
    total_d           = total;
    fill_d            = fill;
    pushed_d          = pushed;
    compressed_d      = compressed;
    o_len_ready       = 1'b0;
    o_wr_en           = 1'b0;
    o_wr_offset       = '0;
    o_wr_len          = '0;
    o_word_push       = 1'b0;
    o_pad_en          = 1'b0;
    o_abort           = 1'b0;
    o_line_valid      = 1'b0;
    o_line_compressed = 1'b0;
    o_line_bits       = '0;

    nt         = {1'b0, total} + (BITS_W+1)'(i_len);
    nf         = LEN_W'(fill) + i_len;
    pushed_inc = pushed + PUSH_W'(1);
    last_sym   = (sym_cnt == CNT_W'(N_SYMBOLS - 1));
    overflow   = (nt > (BITS_W+1)'(CACHE_LINE));

    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_d      = S_ACCEPT;
          sym_cnt_d    = '0;
          total_d      = '0;
          fill_d       = '0;
          pushed_d     = '0;
          compressed_d = 1'b1;
        end
      end

      S_ACCEPT: begin
        o_len_ready = 1'b1;
        if (i_len_valid) begin
          sym_cnt_d = sym_cnt + CNT_W'(1);
          if (overflow) begin
            o_abort      = 1'b1;
            compressed_d = 1'b0;
            state_d      = last_sym ? S_DONE : S_DRAIN;
          end else begin
            o_wr_en     = (i_len != '0);
            o_wr_offset = fill;
            o_wr_len    = i_len;
            total_d     = nt[BITS_W-1:0];
            if (nf >= LEN_W'(WORD_SIZE)) begin
              o_word_push = 1'b1;
              fill_d      = OFF_W'(nf - LEN_W'(WORD_SIZE));
              pushed_d    = pushed_inc;
            end else begin
              fill_d = nf[OFF_W-1:0];
            end
            if (last_sym) begin
              state_d = (pushed_d == PUSH_W'(LINE_WORDS)) ? S_DONE : S_PAD;
            end
          end
        end
      end

      // Close the partial word, then emit all-zero words until the line is full
      S_PAD: begin
        o_pad_en    = 1'b1;
        o_word_push = 1'b1;
        o_wr_offset = fill;
        fill_d      = '0;
        pushed_d    = pushed_inc;
        if (pushed_inc == PUSH_W'(LINE_WORDS)) begin
          state_d = S_DONE;
        end
      end

      S_DRAIN: begin
        o_len_ready = 1'b1;
        if (i_len_valid) begin
          sym_cnt_d = sym_cnt + CNT_W'(1);
          if (last_sym) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        o_line_valid      = 1'b1;
        o_line_compressed = compressed;
        o_line_bits       = compressed ? total : '0;
        if (i_line_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    o_busy = (state != S_IDLE);
  end

endmodule
